// File: rtl/johnson_seq_if.sv
// johnson_seq_if: command and status bundle for the Johnson ring sequencer
interface johnson_seq_if #(
    parameter int WIDTH = 4,
    parameter int CYC_W = 8
);
    logic               start;
    logic [CYC_W-1:0]   num_cycles;
    logic               dir;
    logic               pause;
    logic               abort;
    logic [WIDTH-1:0]   q;
    logic [2*WIDTH-1:0] phase;
    logic               busy;
    logic               paused;
    logic               done;
    logic [CYC_W-1:0]   cycles_done;
    modport master (
        output start, num_cycles, dir, pause, abort,
        input  q, phase, busy, paused, done, cycles_done
    );
    modport slave (
        input  start, num_cycles, dir, pause, abort,
        output q, phase, busy, paused, done, cycles_done
    );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: bounded, direction-controlled Johnson ring sequencer with pause/abort
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CYC_W = 8
) (
    input logic clk,
    input logic rst,
    johnson_seq_if.slave bus
);
    localparam int P = 2 * WIDTH;
    localparam int K_W = $clog2(P) + 1;
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] q, q_n, q_step;
    logic [CYC_W-1:0] cnt, cnt_n, cnt_inc, len, len_n;
    logic dir_r, dir_n;
    logic [K_W-1:0] ones, k;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            cnt   <= '0;
            len   <= '0;
            dir_r <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            cnt   <= cnt_n;
            len   <= len_n;
            dir_r <= dir_n;
        end
    end
    always_comb begin
        q_step  = dir_r ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
        cnt_inc = cnt + CYC_W'(1);
        state_n = state;
        q_n     = q;
        cnt_n   = cnt;
        len_n   = len;
        dir_n   = dir_r;
        case (state)
            IDLE: if (bus.start) begin
                len_n   = bus.num_cycles;
                dir_n   = bus.dir;
                cnt_n   = '0;
                state_n = (bus.num_cycles != '0) ? RUN : DONE;
            end
            RUN: if (bus.abort) begin
                state_n = IDLE;
                q_n     = '0;
            end else if (bus.pause) begin
                state_n = PAUSED;
            end else begin
                q_n = q_step;
                // returning to all-zeros closes one full ring cycle
                if (q_step == '0) begin
                    cnt_n   = cnt_inc;
                    state_n = (cnt_inc == len) ? DONE : RUN;
                end
            end
            PAUSED: if (bus.abort) begin
                state_n = IDLE;
                q_n     = '0;
            end else if (!bus.pause) begin
                state_n = RUN;
            end
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) ones = ones + K_W'(q[i]);
        k = q[WIDTH-1] ? K_W'(P) - ones : ones;
    end
    assign bus.phase       = P'(1) << k;
    assign bus.q           = q;
    assign bus.busy        = (state == RUN) || (state == PAUSED);
    assign bus.paused      = state == PAUSED;
    assign bus.done        = state == DONE;
    assign bus.cycles_done = cnt;
endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
- Sequencer for a WIDTH-stage Johnson (twisted-ring) counter.
- Accepts a start command with a run length in full ring cycles and a direction, then steps the ring one state per clock.
- Supports pause/resume and abort; reports progress, the decoded one-hot phase and a done pulse.
- Used wherever the design needs a bounded, direction-controlled multi-phase sequence, rather than a free-running Johnson counter.

Parameters:
- WIDTH, 4, number of Johnson stages; ring period = 2*WIDTH states.
- CYC_W, 8, width of the run-length and cycle-progress counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- num_cycles  input  CYC_W  number of full ring cycles to run; latched on an accepted start.
- dir  input  1  0 = forward, 1 = reverse; latched on an accepted start.
- pause  input  1  level; holds the ring while high.
- abort  input  1  level/pulse; terminates the run.
- q  output  WIDTH  Johnson counter state.
- phase  output  2*WIDTH  one-hot decode of q.
- busy  output  1  high in RUN or PAUSED.
- paused  output  1  high in PAUSED.
- done  output  1  one-cycle completion pulse.
- cycles_done  output  CYC_W  full ring cycles completed in the current or last run.

Behaviour:
- Reset (async, immediate, no edge needed):
  - state = IDLE, q = 0, busy = 0, paused = 0, done = 0, cycles_done = 0.
  - Latched length and direction registers are cleared.
- FSM states: IDLE, RUN, PAUSED, DONE. busy, paused and done are Moore outputs of the state.
- IDLE, on start:
  - num_cycles != 0: go to RUN; latch num_cycles and dir; clear cycles_done; q stays 0 on that edge.
  - num_cycles == 0: go to DONE; q unchanged; busy never asserts.
- RUN:
  - Priority: abort > pause > step.
  - abort: go to IDLE, q = 0, no done pulse; cycles_done holds its value.
  - pause: go to PAUSED; q holds; no step on that edge.
  - Otherwise step q:
    - Forward: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
    - Reverse: q <= {~q[0], q[WIDTH-1:1]}.
  - A step whose result is q == 0 completes one cycle; cycles_done increments on that edge.
  - If the incremented value equals the latched num_cycles, go to DONE on the same edge.
- PAUSED:
  - q holds.
  - abort: go to IDLE, q = 0.
  - pause low: go to RUN, no step that edge. Resume latency is 1 cycle.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - q = 0 and cycles_done = num_cycles.
  - start is ignored in DONE.
- start is ignored in RUN, PAUSED and DONE. Inputs dir and num_cycles are don't-care except on the accepting edge.
- Run timing: with no pauses, a run takes num_cycles*2*WIDTH stepping edges after the accept edge. done is high in the cycle following the final step.
- phase (combinational from q):
  - Index k = popcount(q) if q[WIDTH-1] == 0, else 2*WIDTH - popcount(q).
  - phase[k] = 1, all other bits 0.
  - In IDLE, phase = 1 (bit 0).
- Forward WIDTH=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000 → k = 0..7.
- Reverse visits the same states in reverse order, so k runs 0, 7, 6, …, 1.
- Arithmetic: cycles_done never wraps within a run, because the run ends when it equals num_cycles (≤ 2^CYC_W-1).

Test Plan:
- WIDTH=4. Reset, then start with num_cycles=2, dir=0 → busy=1 after the accept edge; q steps 0001…1000, 0000 twice (16 edges); cycles_done reads 1 then 2; done high exactly 1 cycle with q=0000; then busy=0.
- start with num_cycles=1, dir=1 → q = 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; phase = 0x80, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02, 0x01; done pulses once.
- Forward run; assert pause for 3 cycles when q=0111 → paused=1 for 3 cycles; q holds 0111 for 4 cycles (3 plus resume); done is delayed by exactly 4 cycles against the unpaused run.
- Assert abort when q=1110 (also abort asserted together with pause) → next cycle state IDLE, q=0000, busy=0, done never asserts.
- start with num_cycles=0 → done pulses 1 cycle; q stays 0000; busy stays 0. A second start pulse during RUN is ignored: the run length is unchanged and only one done pulse occurs.
- Assert rst asynchronously mid-run (between clock edges, q=0111) → q=0000, busy=0, cycles_done=0 immediately; a new start after release runs normally.
